// File: rtl/sse_stream_driver.sv
// Initiator side of the SSE operand handshake: streams a host-loaded buffer of
// operand pairs to a responder, issues one stop pulse, then drains and captures results.
module sse_stream_driver #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_a,
    input  logic [31:0]   wr_b,
    input  logic [AW:0]   len,
    input  logic          go,
    input  logic          hold,
    input  logic          sse_next,
    input  logic          sse_ready,
    input  logic [31:0]   sse_y,
    output logic [31:0]   sse_a,
    output logic [31:0]   sse_b,
    output logic          sse_pause,
    output logic          sse_stop,
    output logic          busy,
    output logic          done,
    output logic [31:0]   result,
    output logic [AW+1:0] result_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [AW:0]    DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [DCW-1:0] DRAIN_MAX = DCW'(DRAIN_TIMEOUT - 1);

    logic [31:0]    buf_a [DEPTH];
    logic [31:0]    buf_b [DEPTH];
    logic [1:0]     state;
    logic [AW:0]    run_len;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  idx_nx;
    logic [DCW-1:0] drain_cnt;
    logic           consume;
    logic           last_pair;
    logic           capture;
    logic [AW:0]    len_clamped;

    // Host writes are locked out for the whole run so the streamed data cannot shift under the responder.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            buf_a[wr_addr] <= wr_a;
            buf_b[wr_addr] <= wr_b;
        end
    end

    assign idx_nx      = idx + 1'b1;
    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    assign consume     = (state == S_STREAM) && sse_next && !sse_pause && !sse_stop;
    assign last_pair   = ({1'b0, idx} == (run_len - 1'b1));
    assign capture     = sse_ready && ((state == S_STREAM) || (state == S_DRAIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            run_len      <= '0;
            idx          <= '0;
            sse_a        <= '0;
            sse_b        <= '0;
            sse_pause    <= 1'b1;
            sse_stop     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            result_count <= '0;
            drain_cnt    <= '0;
        end else begin
            sse_stop <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (go && (len != '0)) begin
                        run_len      <= len_clamped;
                        idx          <= '0;
                        sse_a        <= buf_a[0];
                        sse_b        <= buf_b[0];
                        result       <= '0;
                        result_count <= '0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    sse_pause <= hold;
                    if (consume) begin
                        if (last_pair) begin
                            sse_stop  <= 1'b1;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            idx   <= idx_nx;
                            sse_a <= buf_a[idx_nx];
                            sse_b <= buf_b[idx_nx];
                        end
                    end
                end
                S_DRAIN: begin
                    sse_pause <= hold;
                    // A result arriving on the timeout edge restarts the wait instead of ending the run.
                    if (sse_ready) begin
                        drain_cnt <= '0;
                    end else if (!sse_pause) begin
                        if (drain_cnt == DRAIN_MAX) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            sse_pause <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (capture) begin
                result <= sse_y;
                if (result_count != '1)
                    result_count <= result_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sse_stream_driver.sv
// Directed bench for sse_stream_driver: scripted responder, per-scenario tasks with inline checks.
module tb_sse_stream_driver;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DT    = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_a = '0, wr_b = '0;
    logic [AW:0]   len = '0;
    logic          go = 1'b0, hold = 1'b0, sse_next = 1'b0, sse_ready = 1'b0;
    logic [31:0]   sse_y = '0;
    logic [31:0]   sse_a, sse_b, result;
    logic          sse_pause, sse_stop, busy, done;
    logic [AW+1:0] result_count;

    int errors = 0;
    int checks = 0;

    sse_stream_driver #(.DEPTH(DEPTH), .AW(AW), .DRAIN_TIMEOUT(DT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
        .len(len), .go(go), .hold(hold), .sse_next(sse_next), .sse_ready(sse_ready),
        .sse_y(sse_y), .sse_a(sse_a), .sse_b(sse_b), .sse_pause(sse_pause),
        .sse_stop(sse_stop), .busy(busy), .done(done), .result(result),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    task automatic write_pair(input int addr, input logic [31:0] a, input logic [31:0] b);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go_run(input int n);
        len = (AW+1)'(n); go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sse_pause, sse_stop, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: pause/stop/busy/done=%b required 1000", {sse_pause, sse_stop, busy, done});
        end
        checks++;
        if (sse_a !== 32'h0 || sse_b !== 32'h0 || result !== 32'h0 || result_count !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h result=%h count=%0d required all 0", sse_a, sse_b, result, result_count);
        end
    endtask

    task automatic test_len_zero();
        go_run(0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sse_pause !== 1'b1 || sse_a !== 32'h0) begin
            errors++;
            $display("FAIL len_zero: busy=%b done=%b pause=%b a=%h required 0 0 1 0", busy, done, sse_pause, sse_a);
        end
    endtask

    task automatic test_stream_drain();
        logic [31:0] exp_a [4];
        int n;
        exp_a[0] = 32'h40400000; exp_a[1] = 32'h40A00000; exp_a[2] = 32'h40000000; exp_a[3] = 32'h3F800000;
        for (int i = 0; i < 4; i++) write_pair(i, exp_a[i], 32'h3F800000);
        go_run(4);
        checks++;
        if (busy !== 1'b1 || sse_a !== exp_a[0] || sse_b !== 32'h3F800000) begin
            errors++;
            $display("FAIL go_start: busy=%b a=%h b=%h required 1 %h 3f800000", busy, sse_a, sse_b, exp_a[0]);
        end
        for (int i = 0; i < 4; i++) begin
            repeat (5) begin
                @(negedge clk);
                checks++;
                if (sse_a !== exp_a[i] || sse_stop !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_stable[%0d]: a=%h stop=%b required %h 0", i, sse_a, sse_stop, exp_a[i]);
                end
            end
            sse_next = 1'b1;
            @(negedge clk);
            sse_next = 1'b0;
            checks++;
            if (i < 3) begin
                if (sse_a !== exp_a[i+1] || sse_stop !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_adv[%0d]: a=%h stop=%b required %h 0", i, sse_a, sse_stop, exp_a[i+1]);
                end
            end else if (sse_a !== exp_a[3] || sse_stop !== 1'b1) begin
                errors++;
                $display("FAIL stop_pulse: a=%h stop=%b required %h 1", sse_a, sse_stop, exp_a[3]);
            end
        end
        @(negedge clk);
        checks++;
        if (sse_stop !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry: stop=%b busy=%b done=%b required 0 1 0", sse_stop, busy, done);
        end
        sse_ready = 1'b1; sse_y = 32'h40800000;
        @(negedge clk);
        sse_ready = 1'b0;
        repeat (2) @(negedge clk);
        sse_ready = 1'b1; sse_y = 32'h41500000;
        @(negedge clk);
        sse_ready = 1'b0;
        checks++;
        if (result !== 32'h41500000 || result_count !== 6'd2) begin
            errors++;
            $display("FAIL drain_capture: result=%h count=%0d required 41500000 2", result, result_count);
        end
        wait_done(200, n);
        checks++;
        if (n !== DT) begin
            errors++;
            $display("FAIL drain_timeout: done after %0d cycles required %0d", n, DT);
        end
        checks++;
        if (busy !== 1'b0 || sse_pause !== 1'b1 || result !== 32'h41500000 || result_count !== 6'd2) begin
            errors++;
            $display("FAIL done_state: busy=%b pause=%b result=%h count=%0d required 0 1 41500000 2",
                     busy, sse_pause, result, result_count);
        end
    endtask

    task automatic test_hold();
        int n;
        go_run(4);
        @(negedge clk);
        hold = 1'b1; sse_next = 1'b1;
        @(negedge clk);
        checks++;
        if (sse_pause !== 1'b1 || sse_a !== 32'h40A00000) begin
            errors++;
            $display("FAIL hold_rise: pause=%b a=%h required 1 40a00000", sse_pause, sse_a);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (sse_pause !== 1'b1 || sse_a !== 32'h40A00000) begin
                errors++;
                $display("FAIL hold_stall: pause=%b a=%h required 1 40a00000", sse_pause, sse_a);
            end
        end
        hold = 1'b0;
        @(negedge clk);
        checks++;
        if (sse_pause !== 1'b0 || sse_a !== 32'h40A00000) begin
            errors++;
            $display("FAIL hold_fall: pause=%b a=%h required 0 40a00000", sse_pause, sse_a);
        end
        @(negedge clk);
        checks++;
        if (sse_a !== 32'h40000000) begin
            errors++;
            $display("FAIL hold_resume: a=%h required 40000000", sse_a);
        end
        @(negedge clk);
        @(negedge clk);
        sse_next = 1'b0;
        checks++;
        if (sse_stop !== 1'b1 || sse_a !== 32'h3F800000) begin
            errors++;
            $display("FAIL hold_stop: stop=%b a=%h required 1 3f800000", sse_stop, sse_a);
        end
        wait_done(200, n);
        checks++;
        if (result_count !== 6'd0) begin
            errors++;
            $display("FAIL hold_count: count=%0d required 0", result_count);
        end
    endtask

    task automatic test_len_clamp();
        int n;
        for (int i = 0; i < DEPTH; i++) write_pair(i, 32'(100 + i), ~32'(i));
        go_run(20);
        @(negedge clk);
        sse_next = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            checks++;
            if (k < DEPTH) begin
                if (sse_a !== 32'(100 + k) || sse_b !== ~32'(k) || sse_stop !== 1'b0) begin
                    errors++;
                    $display("FAIL clamp_seq[%0d]: a=%0d stop=%b required %0d 0", k, sse_a, sse_stop, 100 + k);
                end
            end else if (sse_stop !== 1'b1 || sse_a !== 32'd115) begin
                errors++;
                $display("FAIL clamp_stop: stop=%b a=%0d required 1 115", sse_stop, sse_a);
            end
        end
        @(negedge clk);
        sse_next = 1'b0;
        checks++;
        if (sse_stop !== 1'b0 || sse_a !== 32'd115) begin
            errors++;
            $display("FAIL clamp_after: stop=%b a=%0d required 0 115", sse_stop, sse_a);
        end
        wait_done(200, n);
    endtask

    task automatic test_rst_mid_run();
        int n;
        go_run(4);
        @(negedge clk);
        sse_next = 1'b1; sse_ready = 1'b1; sse_y = 32'h12345678;
        @(negedge clk);
        sse_ready = 1'b0;
        @(negedge clk);
        sse_next = 1'b0;
        checks++;
        if (sse_a !== 32'd102 || result !== 32'h12345678 || result_count !== 6'd1) begin
            errors++;
            $display("FAIL ready_with_consume: a=%0d result=%h count=%0d required 102 12345678 1",
                     sse_a, result, result_count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (sse_pause !== 1'b1 || sse_stop !== 1'b0 || busy !== 1'b0 || result_count !== '0 || sse_a !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: pause=%b stop=%b busy=%b count=%0d a=%h required 1 0 0 0 0",
                     sse_pause, sse_stop, busy, result_count, sse_a);
        end
        go_run(1);
        @(negedge clk);
        sse_next = 1'b1;
        @(negedge clk);
        sse_next = 1'b0;
        checks++;
        if (sse_stop !== 1'b1 || sse_a !== 32'd100) begin
            errors++;
            $display("FAIL len1_stop: stop=%b a=%0d required 1 100", sse_stop, sse_a);
        end
        @(negedge clk);
        checks++;
        if (sse_stop !== 1'b0) begin
            errors++;
            $display("FAIL len1_single: stop=%b required 0", sse_stop);
        end
        wait_done(200, n);
    endtask

    task automatic test_write_while_busy();
        int n;
        go_run(1);
        wr_en = 1'b1; wr_addr = '0; wr_a = 32'h7F800000; wr_b = 32'h7F800000;
        @(negedge clk);
        wr_en = 1'b0; sse_next = 1'b1;
        @(negedge clk);
        sse_next = 1'b0;
        wait_done(200, n);
        go_run(1);
        checks++;
        if (sse_a !== 32'd100 || sse_b !== ~32'd0) begin
            errors++;
            $display("FAIL write_busy: a=%h b=%h required 00000064 ffffffff", sse_a, sse_b);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_len_zero();
        test_stream_drain();
        test_hold();
        test_len_clamp();
        test_rst_mid_run();
        test_write_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
